mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 159 +++++++++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one load or store per request, waits for
// a one-cycle ack with a bounded timeout, and reports completion and writeback.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [15:0] true_addr,
    input  logic [15:0] store_data,
    input  logic [2:0]  dest_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wb_en,
    output logic [2:0]  wb_reg,
    output logic [15:0] load_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        op_load_r, op_load_s;
    logic [15:0] addr_r, addr_s;
    logic [15:0] wdata_r, wdata_s;
    logic [2:0]  dest_r, dest_s;
    logic [15:0] load_data_r, load_data_s;
    logic        mem_req_r, mem_req_s;
    logic        mem_we_r, mem_we_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic        wb_en_r, wb_en_s;

    // Next-state, latch and registered-output decode
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        op_load_s   = op_load_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        dest_s      = dest_r;
        load_data_s = load_data_r;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        wb_en_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (start && (is_load ^ is_store)) begin
                    state_s   = ACCESS;
                    cnt_s     = 8'd0;
                    op_load_s = is_load;
                    addr_s    = true_addr;
                    wdata_s   = store_data;
                    dest_s    = dest_reg;
                    mem_req_s = 1'b1;
                    mem_we_s  = is_store;
                end else if (start && is_load && is_store) begin
                    // Conflicting op: flag it without touching memory
                    err_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle still counts as success
                if (mem_ack) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    wb_en_s = op_load_r;
                    if (op_load_r) begin
                        load_data_s = mem_rdata;
                    end else begin
                        load_data_s = load_data_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else begin
                    cnt_s     = cnt_r + 8'd1;
                    mem_req_s = 1'b1;
                    mem_we_s  = ~op_load_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, latched operands and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            op_load_r   <= 1'b0;
            addr_r      <= 16'd0;
            wdata_r     <= 16'd0;
            dest_r      <= 3'd0;
            load_data_r <= 16'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            wb_en_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            op_load_r   <= op_load_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            dest_r      <= dest_s;
            load_data_r <= load_data_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            wb_en_r     <= wb_en_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign wb_en     = wb_en_r;
    assign wb_reg    = dest_r;
    assign load_data = load_data_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short timeout; completions are checked
// against a scoreboard of expected results queued as each request is driven.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, start, is_load, is_store, mem_ack;
    logic [15:0] true_addr, store_data, mem_rdata;
    logic [2:0]  dest_reg;
    logic        mem_req, mem_we, busy, done, err, wb_en;
    logic [15:0] mem_addr, mem_wdata, load_data;
    logic [2:0]  wb_reg;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        done;
        logic        err;
        logic        wb_en;
        logic [2:0]  wb_reg;
        logic [15:0] ld;
    } exp_t;

    exp_t sb_q[$];

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .true_addr(true_addr), .store_data(store_data), .dest_reg(dest_reg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err),
        .wb_en(wb_en), .wb_reg(wb_reg), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic ld, input logic st,
                         input logic [15:0] a, input logic [15:0] d, input logic [2:0] r);
        start = s; is_load = ld; is_store = st; true_addr = a; store_data = d; dest_reg = r;
    endtask

    // Wait (bounded) for a done or err pulse, then compare against the queue head
    task automatic wait_done(input string tag);
        exp_t e;
        int   n = 0;
        while (!(done || err) && n < 20) begin
            step();
            n++;
        end
        if (!(done || err)) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_done"},  32'(done),      32'(e.done));
            chk({tag, "_err"},   32'(err),       32'(e.err));
            chk({tag, "_wb_en"}, 32'(wb_en),     32'(e.wb_en));
            chk({tag, "_wbreg"}, 32'(wb_reg),    32'(e.wb_reg));
            chk({tag, "_ldata"}, 32'(load_data), 32'(e.ld));
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_q_done"}, 32'(done),    32'd0);
        chk({tag, "_q_busy"}, 32'(busy),    32'd0);
        chk({tag, "_q_req"},  32'(mem_req), 32'd0);
        chk({tag, "_q_wben"}, 32'(wb_en),   32'd0);
    endtask

    initial begin
        int nreq;
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        step(); step();
        chk("rst_req",   32'(mem_req),   32'd0);
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_ldata", 32'(load_data), 32'd0);
        chk("rst_wbreg", 32'(wb_reg),    32'd0);
        check_quiet("rst");
        rst = 1'b0;
        step();

        // Load 0x1234 -> r5, ack in first access cycle
        drive(1'b1, 1'b1, 1'b0, 16'h1234, 16'h7777, 3'd5);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        chk("ld_req",  32'(mem_req),  32'd1);
        chk("ld_we",   32'(mem_we),   32'd0);
        chk("ld_addr", 32'(mem_addr), 32'h1234);
        chk("ld_busy", 32'(busy),     32'd1);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        sb_q.push_back('{1'b1, 1'b0, 1'b1, 3'd5, 16'hBEEF});
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("ld_done_busy", 32'(busy),    32'd1);
        chk("ld_done_req",  32'(mem_req), 32'd0);
        wait_done("ld");
        step();
        check_quiet("ld_after");

        // Store 0xFFFF <- 0x00A5, ack on third access cycle, operands held
        drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h00A5, 3'd2);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'h5555, 16'hAAAA, 3'd0);
        for (int i = 0; i < 3; i++) begin
            chk("st_req",   32'(mem_req),   32'd1);
            chk("st_we",    32'(mem_we),    32'd1);
            chk("st_addr",  32'(mem_addr),  32'hFFFF);
            chk("st_wdata", 32'(mem_wdata), 32'h00A5);
            if (i == 2) begin
                mem_ack = 1'b1;
                sb_q.push_back('{1'b1, 1'b0, 1'b0, 3'd2, 16'hBEEF});
            end
            step();
        end
        mem_ack = 1'b0;
        wait_done("st");
        step();
        check_quiet("st_after");

        // Load with no ack: times out after four request cycles
        drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 3'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        sb_q.push_back('{1'b1, 1'b1, 1'b0, 3'd3, 16'hBEEF});
        nreq = 0;
        while (mem_req && nreq < 20) begin
            nreq++;
            step();
        end
        chk("to_req_cycles", 32'(nreq), 32'd4);
        wait_done("to");
        step();
        check_quiet("to_after");
        chk("to_err_clear", 32'(err), 32'd0);

        // Ack on the fourth (last) access cycle wins over the timeout
        drive(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 3'd7);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        step(); step(); step();
        chk("edge_req4", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        sb_q.push_back('{1'b1, 1'b0, 1'b1, 3'd7, 16'h5A5A});
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        wait_done("edge");
        step();
        check_quiet("edge_after");

        // Both load and store: error pulse only, no access
        drive(1'b1, 1'b1, 1'b1, 16'h0300, 16'h0000, 3'd4);
        sb_q.push_back('{1'b0, 1'b1, 1'b0, 3'd7, 16'h5A5A});
        step();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        check_quiet("both");
        wait_done("both");
        step();
        chk("both_err_clear", 32'(err), 32'd0);

        // Neither op flag: ignored
        drive(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000, 3'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        check_quiet("neither");
        chk("neither_err", 32'(err), 32'd0);

        // Start held while busy must not launch a second access
        drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 3'd1);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0999, 16'h1234, 3'd6);
        step();
        chk("busy_addr", 32'(mem_addr), 32'h0100);
        chk("busy_we",   32'(mem_we),   32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        sb_q.push_back('{1'b1, 1'b0, 1'b1, 3'd1, 16'h1111});
        step();
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        wait_done("busy");
        step();
        check_quiet("busy_after");
        step();
        check_quiet("busy_after2");

        // Reset mid-access, then a stray ack
        drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 3'd6);
        step();
        chk("rsta_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0);
        check_quiet("rsta");
        chk("rsta_addr",  32'(mem_addr),  32'd0);
        chk("rsta_ldata", 32'(load_data), 32'd0);
        chk("rsta_wbreg", 32'(wb_reg),    32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        check_quiet("rsta_ack");
        chk("rsta_ack_err",   32'(err),       32'd0);
        chk("rsta_ack_ldata", 32'(load_data), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
